// File: rtl/bird_tally_if.sv
// Signal bundle between the movement/firing FSMs, bird_tally and the display path.
// master drives the bird-event strobes; slave (bird_tally) drives the tallies and score digits.
interface bird_tally_if #(
    parameter int SCORE_W = 14
);
    logic               leave;
    logic               escape;
    logic               is_shot;
    logic [9:0]         birds;
    logic [3:0]         birds_hit;
    logic [3:0]         birds_lost;
    logic [SCORE_W-1:0] score;
    logic [3:0]         score_ones;
    logic [3:0]         score_tens;
    logic [3:0]         score_hundreds;
    logic [3:0]         score_thousands;
    logic               bcd_valid;
    logic [3:0]         round;
    logic               game_over;

    modport master (
        output leave, escape, is_shot,
        input  birds, birds_hit, birds_lost, score,
        input  score_ones, score_tens, score_hundreds, score_thousands,
        input  bcd_valid, round, game_over
    );

    modport slave (
        input  leave, escape, is_shot,
        output birds, birds_hit, birds_lost, score,
        output score_ones, score_tens, score_hundreds, score_thousands,
        output bcd_valid, round, game_over
    );
endinterface

// File: rtl/bird_tally.sv
// Per-bird result bookkeeping: tallies, slot mask, score, round, game-over, plus an
// iterative double-dabble score-to-BCD converter. Optional macro PERFECT_BONUS_EN adds a perfect-round bonus.
module bird_tally #(
    parameter int BIRDS_PER_ROUND = 10,
    parameter int HIT_POINTS      = 50,
    parameter int ESCAPE_PENALTY  = 10,
    parameter int SCORE_W         = 14,
    parameter int MAX_SCORE       = 9999
) (
    input logic       clk,
    input logic       reset,
    bird_tally_if.slave bus
);
    localparam int CNT_W = $clog2(SCORE_W);
    localparam int SUM_W = SCORE_W + 11;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} bcd_state_t;

    function automatic logic [SCORE_W-1:0] sat_add(input logic [SCORE_W-1:0] a, input int unsigned b);
        logic [SUM_W-1:0] s;
        s = SUM_W'(a) + SUM_W'(b);
        if (s > SUM_W'(MAX_SCORE))
            return SCORE_W'(MAX_SCORE);
        return s[SCORE_W-1:0];
    endfunction

    logic               leave_q_reg;
    logic [9:0]         birds_reg, birds_next;
    logic [3:0]         hit_reg, hit_next;
    logic [3:0]         lost_reg, lost_next;
    logic [3:0]         round_reg, round_next;
    logic [SCORE_W-1:0] score_reg, score_next;
    logic               game_over_reg, game_over_next;
    logic [4:0]         total_next;
    logic               evt;

    always_comb begin
        birds_next     = birds_reg;
        hit_next       = hit_reg;
        lost_next      = lost_reg;
        round_next     = round_reg;
        score_next     = score_reg;
        game_over_next = game_over_reg;
        total_next     = 5'd0;
        evt            = bus.leave & ~leave_q_reg & ~game_over_reg;

        // Events with neither qualifier leave everything untouched, including the round-end check.
        if (evt && (bus.escape || bus.is_shot)) begin
            if (bus.escape) begin
                lost_next  = lost_reg + 4'd1;
                score_next = (score_reg < SCORE_W'(ESCAPE_PENALTY)) ? '0
                                                                    : score_reg - SCORE_W'(ESCAPE_PENALTY);
            end else begin
                birds_next = birds_reg & ~(10'd1 << (hit_reg + lost_reg));
                hit_next   = hit_reg + 4'd1;
                score_next = sat_add(score_reg, HIT_POINTS);
            end

            total_next = {1'b0, hit_next} + {1'b0, lost_next};
            if (total_next == 5'(BIRDS_PER_ROUND)) begin
                if (hit_next >= lost_next) begin
`ifdef PERFECT_BONUS_EN
                    if (lost_next == 4'd0)
                        score_next = sat_add(score_next, 500);
`endif
                    birds_next = 10'h3FF;
                    hit_next   = 4'd0;
                    lost_next  = 4'd0;
                    if (round_reg != 4'hF)
                        round_next = round_reg + 4'd1;
                end else begin
                    game_over_next = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            leave_q_reg   <= 1'b0;
            birds_reg     <= 10'h3FF;
            hit_reg       <= 4'd0;
            lost_reg      <= 4'd0;
            round_reg     <= 4'd0;
            score_reg     <= '0;
            game_over_reg <= 1'b0;
        end else begin
            leave_q_reg   <= bus.leave;
            birds_reg     <= birds_next;
            hit_reg       <= hit_next;
            lost_reg      <= lost_next;
            round_reg     <= round_next;
            score_reg     <= score_next;
            game_over_reg <= game_over_next;
        end
    end

    bcd_state_t         state_reg;
    logic [SCORE_W-1:0] src_reg;
    logic [SCORE_W-1:0] shift_reg;
    logic [15:0]        scratch_reg;
    logic [15:0]        digits_reg;
    logic [CNT_W-1:0]   count_reg;
    logic               valid_reg;
    logic [15:0]        adj;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_adj
            assign adj[gi*4 +: 4] = (scratch_reg[gi*4 +: 4] >= 4'd5) ? scratch_reg[gi*4 +: 4] + 4'd3
                                                                     : scratch_reg[gi*4 +: 4];
        end
    endgenerate

    // src_reg holds the score under conversion; any difference from score_reg acts as the pending flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            src_reg     <= '0;
            shift_reg   <= '0;
            scratch_reg <= 16'd0;
            digits_reg  <= 16'd0;
            count_reg   <= '0;
            valid_reg   <= 1'b1;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (score_reg != src_reg) begin
                        src_reg     <= score_reg;
                        shift_reg   <= score_reg;
                        scratch_reg <= 16'd0;
                        count_reg   <= '0;
                        valid_reg   <= 1'b0;
                        state_reg   <= SHIFT;
                    end
                end
                SHIFT: begin
                    scratch_reg <= {adj[14:0], shift_reg[SCORE_W-1]};
                    shift_reg   <= {shift_reg[SCORE_W-2:0], 1'b0};
                    count_reg   <= count_reg + 1'b1;
                    if (count_reg == CNT_W'(SCORE_W - 1))
                        state_reg <= DONE;
                end
                DONE: begin
                    digits_reg <= scratch_reg;
                    if (score_reg != src_reg) begin
                        src_reg     <= score_reg;
                        shift_reg   <= score_reg;
                        scratch_reg <= 16'd0;
                        count_reg   <= '0;
                        state_reg   <= SHIFT;
                    end else begin
                        valid_reg <= 1'b1;
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.birds           = birds_reg;
    assign bus.birds_hit       = hit_reg;
    assign bus.birds_lost      = lost_reg;
    assign bus.score           = score_reg;
    assign bus.round           = round_reg;
    assign bus.game_over       = game_over_reg;
    assign bus.score_ones      = digits_reg[3:0];
    assign bus.score_tens      = digits_reg[7:4];
    assign bus.score_hundreds  = digits_reg[11:8];
    assign bus.score_thousands = digits_reg[15:12];
    assign bus.bcd_valid       = valid_reg;
endmodule

// File: tb/tb_bird_tally.sv
// Self-checking bench for bird_tally: directed scenarios plus randomized bird events
// compared against an arithmetic model of the tally/score rules.
module tb_bird_tally;
    localparam int BPR  = 10;
    localparam int HIT  = 50;
    localparam int PEN  = 10;
    localparam int SW   = 14;
    localparam int MAXS = 9999;

    logic clk = 1'b0;
    logic reset = 1'b1;

    bird_tally_if #(.SCORE_W(SW)) bus();

    bird_tally #(
        .BIRDS_PER_ROUND(BPR),
        .HIT_POINTS(HIT),
        .ESCAPE_PENALTY(PEN),
        .SCORE_W(SW),
        .MAX_SCORE(MAXS)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    always #10 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [9:0] m_birds;
    int         m_hit, m_lost, m_score, m_round;
    logic       m_go;

    task automatic m_reset();
        m_birds = 10'h3FF;
        m_hit = 0; m_lost = 0; m_score = 0; m_round = 0; m_go = 1'b0;
    endtask

    task automatic m_event(input logic esc, input logic shot);
        if (m_go || (!esc && !shot)) return;
        if (esc) begin
            m_lost++;
            m_score = (m_score < PEN) ? 0 : m_score - PEN;
        end else begin
            m_birds[m_hit + m_lost] = 1'b0;
            m_hit++;
            m_score = (m_score + HIT > MAXS) ? MAXS : m_score + HIT;
        end
        if (m_hit + m_lost == BPR) begin
            if (m_hit >= m_lost) begin
`ifdef PERFECT_BONUS_EN
                if (m_lost == 0) m_score = (m_score + 500 > MAXS) ? MAXS : m_score + 500;
`endif
                m_birds = 10'h3FF;
                m_hit = 0;
                m_lost = 0;
                if (m_round < 15) m_round++;
            end else begin
                m_go = 1'b1;
            end
        end
    endtask

    function automatic logic [36:0] exp_state();
        return {m_birds, 4'(m_hit), 4'(m_lost), 14'(m_score), 4'(m_round), m_go};
    endfunction

    function automatic logic [36:0] act_state();
        return {bus.birds, bus.birds_hit, bus.birds_lost, bus.score, bus.round, bus.game_over};
    endfunction

    function automatic logic [15:0] exp_digits();
        return {4'(m_score / 1000), 4'((m_score / 100) % 10), 4'((m_score / 10) % 10), 4'(m_score % 10)};
    endfunction

    function automatic logic [15:0] act_digits();
        return {bus.score_thousands, bus.score_hundreds, bus.score_tens, bus.score_ones};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        bus.leave = 1'b0; bus.escape = 1'b0; bus.is_shot = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        m_reset();
    endtask

    // One leave pulse: qualifiers valid on the edge cycle, junk afterwards while leave stays high.
    task automatic pulse(input logic esc, input logic shot, input int hi);
        @(negedge clk);
        bus.leave = 1'b1; bus.escape = esc; bus.is_shot = shot;
        for (int k = 1; k < hi; k++) begin
            @(negedge clk);
            bus.escape = 1'($urandom); bus.is_shot = 1'($urandom);
        end
        @(negedge clk);
        bus.leave = 1'b0; bus.escape = 1'b0; bus.is_shot = 1'b0;
        m_event(esc, shot);
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 200; k++) begin
            if (bus.bcd_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (act_state() !== exp_state()) begin
            errors++; $display("FAIL reset_state: got %h required %h", act_state(), exp_state());
        end
        checks++;
        if ({act_digits(), bus.bcd_valid} !== {16'h0000, 1'b1}) begin
            errors++; $display("FAIL reset_bcd: got %h/%b required 0000/1", act_digits(), bus.bcd_valid);
        end
        pulse(1'b0, 1'b1, 1);
        repeat (5) @(negedge clk);
        #3 reset = 1'b1;
        #1;
        checks++;
        if ({bus.score, bus.birds, bus.bcd_valid, act_digits()} !== {14'd0, 10'h3FF, 1'b1, 16'h0000}) begin
            errors++; $display("FAIL async_reset: score=%0d birds=%h valid=%b digits=%h required 0/3ff/1/0000",
                               bus.score, bus.birds, bus.bcd_valid, act_digits());
        end
        @(negedge clk);
        reset = 1'b0;
        m_reset();
        $display("test_reset done");
    endtask

    task automatic test_hits_digits();
        bit ok;
        do_reset();
        pulse(1'b0, 1'b1, 1); wait_valid(ok);
        pulse(1'b0, 1'b1, 1); wait_valid(ok);
        pulse(1'b0, 1'b1, 1);
        checks++;
        if (act_state() !== exp_state()) begin
            errors++; $display("FAIL three_hits_state: got %h required %h", act_state(), exp_state());
        end
        repeat (15) @(negedge clk);
        checks++;
        if (bus.bcd_valid !== 1'b0) begin
            errors++; $display("FAIL bcd_early: valid=%b required 0 at 15 cycles", bus.bcd_valid);
        end
        @(negedge clk);
        checks++;
        if ({bus.bcd_valid, act_digits()} !== {1'b1, exp_digits()}) begin
            errors++; $display("FAIL bcd_latency16: valid=%b digits=%h required 1/%h",
                               bus.bcd_valid, act_digits(), exp_digits());
        end
        $display("test_hits_digits score=%0d digits=%h", bus.score, act_digits());
    endtask

    task automatic test_escape_priority();
        do_reset();
        pulse(1'b1, 1'b1, 1);
        checks++;
        if (act_state() !== exp_state()) begin
            errors++; $display("FAIL escape_priority: got %h required %h", act_state(), exp_state());
        end
        $display("test_escape_priority lost=%0d hit=%0d score=%0d", bus.birds_lost, bus.birds_hit, bus.score);
    endtask

    task automatic test_round();
        do_reset();
        repeat (6) pulse(1'b0, 1'b1, 1);
        checks++;
        if (bus.score !== 14'(m_score)) begin
            errors++; $display("FAIL six_hits_score: got %0d required %0d", bus.score, m_score);
        end
        repeat (4) pulse(1'b1, 1'b0, 1);
        checks++;
        if (act_state() !== exp_state()) begin
            errors++; $display("FAIL round_end: got %h required %h", act_state(), exp_state());
        end
        do_reset();
        repeat (10) pulse(1'b0, 1'b1, 1);
        checks++;
        if (act_state() !== exp_state()) begin
            errors++; $display("FAIL perfect_round: got %h required %h", act_state(), exp_state());
        end
        $display("test_round round=%0d score=%0d", bus.round, bus.score);
    endtask

    task automatic test_game_over();
        do_reset();
        repeat (4) pulse(1'b0, 1'b1, 1);
        repeat (6) pulse(1'b1, 1'b0, 1);
        checks++;
        if ({bus.game_over, act_state()} !== {1'b1, exp_state()}) begin
            errors++; $display("FAIL game_over_set: got %b/%h required 1/%h", bus.game_over, act_state(), exp_state());
        end
        pulse(1'b0, 1'b1, 1);
        pulse(1'b1, 1'b0, 1);
        checks++;
        if (act_state() !== exp_state()) begin
            errors++; $display("FAIL game_over_frozen: got %h required %h", act_state(), exp_state());
        end
        $display("test_game_over game_over=%b", bus.game_over);
    endtask

    task automatic test_saturation();
        bit ok;
        do_reset();
        pulse(1'b0, 1'b1, 1); pulse(1'b1, 1'b0, 1);
        pulse(1'b0, 1'b1, 1); pulse(1'b1, 1'b0, 1);
        repeat (198) pulse(1'b0, 1'b1, 1);
        checks++;
        if (act_state() !== exp_state()) begin
            errors++; $display("FAIL near_max: got %h required %h", act_state(), exp_state());
        end
        pulse(1'b0, 1'b1, 1);
        checks++;
        if (act_state() !== exp_state()) begin
            errors++; $display("FAIL saturate: got %h required %h", act_state(), exp_state());
        end
        wait_valid(ok);
        checks++;
        if ({ok, act_digits()} !== {1'b1, exp_digits()}) begin
            errors++; $display("FAIL saturate_digits: ok=%b digits=%h required 1/%h", ok, act_digits(), exp_digits());
        end
        $display("test_saturation score=%0d digits=%h", bus.score, act_digits());
    endtask

    task automatic test_back_to_back();
        bit seen;
        do_reset();
        pulse(1'b0, 1'b1, 1);
        @(negedge clk);
        pulse(1'b0, 1'b1, 1);
        seen = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (bus.bcd_valid === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if ({seen, act_digits()} !== {1'b1, exp_digits()}) begin
            errors++; $display("FAIL back_to_back_digits: seen=%b digits=%h required 1/%h", seen, act_digits(), exp_digits());
        end
        pulse(1'b0, 1'b1, 20);
        checks++;
        if (act_state() !== exp_state()) begin
            errors++; $display("FAIL long_leave: got %h required %h", act_state(), exp_state());
        end
        $display("test_back_to_back score=%0d hit=%0d", bus.score, bus.birds_hit);
    endtask

    task automatic test_random();
        bit ok;
        logic esc, shot;
        do_reset();
        for (int n = 0; n < 150; n++) begin
            esc  = ($urandom % 4) == 0;
            shot = 1'($urandom);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            pulse(esc, shot, int'($urandom_range(1, 3)));
            checks++;
            if (act_state() !== exp_state()) begin
                errors++; $display("FAIL random_event_%0d: got %h required %h", n, act_state(), exp_state());
            end
            if (m_go) do_reset();
        end
        wait_valid(ok);
        checks++;
        if ({ok, act_digits()} !== {1'b1, exp_digits()}) begin
            errors++; $display("FAIL random_digits: ok=%b digits=%h required 1/%h", ok, act_digits(), exp_digits());
        end
        $display("test_random score=%0d round=%0d", bus.score, bus.round);
    endtask

    initial begin
        bus.leave = 1'b0; bus.escape = 1'b0; bus.is_shot = 1'b0;
        m_reset();
        test_reset();
        test_hits_digits();
        test_escape_priority();
        test_round();
        test_game_over();
        test_saturation();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
